backdoor_spi_dff_buffer: RTL and testbench

Parameterised enable-gated shift chain for the backdoor SPI path. One serial bit `i_D` is shifted into a chain of BUFFER_WIDTH+1 flip-flops on each enabled clock edge. The two most-significant stages are exposed as a 2-bit output window. Its uses are to retime and synchronise serial backdoor data and to give downstream logic the current and previous delayed bits.

---
 rtl/backdoor_spi_dff_buffer_pkg.sv | 8 +
 rtl/backdoor_spi_dff.sv | 30 +++
 rtl/backdoor_spi_dff_buffer.sv | 32 +++
 tb/tb_backdoor_spi_dff_buffer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/backdoor_spi_dff_buffer_pkg.sv
// rtl/backdoor_spi_dff_buffer_pkg.sv - shared constants for the backdoor SPI retiming chain
package backdoor_spi_dff_buffer_pkg;

    // Project-wide default depth; o_Q taps stages BUFFER_WIDTH and BUFFER_WIDTH-1.
    localparam int unsigned BDS_BUFFER_WIDTH_DEFAULT = 2;
    localparam int unsigned BDS_WINDOW_WIDTH         = 2;

endpackage

// File: rtl/backdoor_spi_dff.sv
// rtl/backdoor_spi_dff.sv - single enable-gated D flip-flop with async active-low clear
module backdoor_spi_dff (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_EN,
    input  logic i_D,
    output logic o_Q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (i_EN) begin
            q_d = i_D;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_Q = q_q;

endmodule

// File: rtl/backdoor_spi_dff_buffer.sv
// rtl/backdoor_spi_dff_buffer.sv - enable-gated serial shift chain exposing its two oldest stages
module backdoor_spi_dff_buffer
    import backdoor_spi_dff_buffer_pkg::*;
#(
    parameter int unsigned BUFFER_WIDTH = BDS_BUFFER_WIDTH_DEFAULT
) (
    input  logic                        i_CLK,
    input  logic                        i_RST,
    input  logic                        i_EN,
    input  logic                        i_D,
    output logic [BDS_WINDOW_WIDTH-1:0] o_Q
);

    logic [BUFFER_WIDTH:0] r_q;
    logic [BUFFER_WIDTH:0] r_d;

    // Stage 0 takes the serial input; every other stage takes its lower neighbour.
    assign r_d = {r_q[BUFFER_WIDTH-1:0], i_D};

    for (genvar g = 0; g <= BUFFER_WIDTH; g++) begin : g_stage
        backdoor_spi_dff u_dff (
            .i_CLK (i_CLK),
            .i_RST (i_RST),
            .i_EN  (i_EN),
            .i_D   (r_d[g]),
            .o_Q   (r_q[g])
        );
    end

    assign o_Q = r_q[BUFFER_WIDTH -: BDS_WINDOW_WIDTH];

endmodule

// File: tb/tb_backdoor_spi_dff_buffer.sv
// tb/tb_backdoor_spi_dff_buffer.sv - directed vector bench for backdoor_spi_dff_buffer
module tb_backdoor_spi_dff_buffer;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       d;
        logic [1:0] exp_q;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d;
    logic [1:0] q;

    int errors;
    int checks;

    vec_t vecs[$];

    backdoor_spi_dff_buffer #(.BUFFER_WIDTH(2)) dut (
        .i_CLK (clk),
        .i_RST (rst_n),
        .i_EN  (en),
        .i_D   (d),
        .o_Q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic dd, input logic [1:0] x);
        vec_t v;
        v.rst_n = r;
        v.en    = e;
        v.d     = dd;
        v.exp_q = x;
        vecs.push_back(v);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        d      = 1'b1;

        // reset held with data and enable active
        add(0, 1, 1, 2'b00);
        add(0, 1, 1, 2'b00);
        // shift ones
        add(1, 1, 1, 2'b00);
        add(1, 1, 1, 2'b01);
        add(1, 1, 1, 2'b11);
        add(1, 1, 1, 2'b11);
        // shift zeros
        add(0, 0, 0, 2'b00);
        add(1, 1, 0, 2'b00);
        add(1, 1, 0, 2'b00);
        add(1, 1, 0, 2'b00);
        add(1, 1, 0, 2'b00);
        // hold from empty, then fill, then hold while d toggles
        add(0, 0, 0, 2'b00);
        add(1, 0, 1, 2'b00);
        add(1, 0, 1, 2'b00);
        add(1, 0, 1, 2'b00);
        add(1, 0, 1, 2'b00);
        add(1, 1, 1, 2'b00);
        add(1, 1, 1, 2'b01);
        add(1, 1, 1, 2'b11);
        add(1, 0, 0, 2'b11);
        add(1, 0, 1, 2'b11);
        add(1, 0, 0, 2'b11);
        add(1, 0, 1, 2'b11);
        add(1, 0, 0, 2'b11);
        // reset from full, then mixed pattern 1,0,1,1,0
        add(0, 1, 1, 2'b00);
        add(1, 1, 1, 2'b00);
        add(1, 1, 0, 2'b01);
        add(1, 1, 1, 2'b10);
        add(1, 1, 1, 2'b01);
        add(1, 1, 0, 2'b11);
        // pulsed enable: disabled edges do not advance
        add(1, 0, 1, 2'b11);
        add(1, 1, 0, 2'b10);
        add(1, 0, 1, 2'b10);
        add(1, 1, 0, 2'b00);

        #1;
        check("reset_initial", q, 2'b00);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            en    = vecs[i].en;
            d     = vecs[i].d;
            #1;
            if (!vecs[i].rst_n) begin
                check($sformatf("vec%0d_async_clear", i), q, 2'b00);
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), q, vecs[i].exp_q);
        end

        // reset asserted between edges from a full chain
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; d = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_op_full", q, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_op_clear_before_edge", q, 2'b00);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid_op_held%0d", k), q, 2'b00);
        end

        // release mid-cycle with enable low, then first enabled edges
        en = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_no_enable", q, 2'b00);
        @(negedge clk);
        en = 1'b1; d = 1'b1;
        @(posedge clk);
        #1;
        check("release_edge1", q, 2'b00);
        @(posedge clk);
        #1;
        check("release_edge2", q, 2'b01);
        @(posedge clk);
        #1;
        check("release_edge3", q, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
